// File: rtl/cascade_stage_fetcher_pkg.sv
// Shared types and sizes for the cascade cache fetch path.
package cascade_stage_fetcher_pkg;

  localparam int ADDR_WIDTH = 10;
  localparam int WORD_SIZE  = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } fetch_state_t;

  // One cache word plus the end-of-stage marker that travels with it.
  typedef struct packed {
    logic [WORD_SIZE-1:0] data;
    logic                 last;
  } struct_fetch_word;

  // Read port of the cascade cache (address registered inside the cache).
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] raddr;
  } struct_cascadeCache_Read_In;

  typedef struct packed {
    logic [WORD_SIZE-1:0] q;
  } struct_cascadeCache_Read_Out;

endpackage

// File: rtl/cascade_stage_fetcher_if.sv
// Command and output stream handshakes of the stage fetcher.
interface cascade_stage_fetcher_if;
  import cascade_stage_fetcher_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH:0]   cmd_count;

  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_SIZE-1:0]  out_data;
  logic                  out_last;

  // The side that issues stage commands and consumes the word stream.
  modport master (
    output cmd_valid, cmd_addr, cmd_count, out_ready,
    input  cmd_ready, out_valid, out_data, out_last
  );

  // The fetcher itself.
  modport slave (
    input  cmd_valid, cmd_addr, cmd_count, out_ready,
    output cmd_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/cascade_stage_fetcher_skid_fifo.sv
// Small circular FIFO that absorbs words returning from the cache while the
// consumer stalls. Head is presented combinationally.
module cascade_stage_fetcher_skid_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_SLOT  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push and pop together leave count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/cascade_stage_fetcher.sv
// Walks the cascade cache for one stage command and streams the words out,
// hiding the cache's one-cycle read latency behind a small skid FIFO.
// SKID_DEPTH must be at least 2 for back-to-back streaming.
module cascade_stage_fetcher #(
  parameter int ADDR_WIDTH = cascade_stage_fetcher_pkg::ADDR_WIDTH,
  parameter int WORD_SIZE  = cascade_stage_fetcher_pkg::WORD_SIZE,
  parameter int SKID_DEPTH = 2
) (
  input  logic                                              clk,
  input  logic                                              reset,
  cascade_stage_fetcher_if.slave                            bus,
  output cascade_stage_fetcher_pkg::struct_cascadeCache_Read_In  ccr_in,
  input  cascade_stage_fetcher_pkg::struct_cascadeCache_Read_Out ccr_out,
  output logic                                              busy,
  output logic                                              done
);
  import cascade_stage_fetcher_pkg::*;

  localparam int CNT_W  = $clog2(SKID_DEPTH + 1);
  localparam int FIFO_W = $bits(struct_fetch_word);
  localparam logic [CNT_W:0] SKID_LIMIT = (CNT_W + 1)'(SKID_DEPTH);

  fetch_state_t          state;
  fetch_state_t          next_state;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic                  issue;
  logic                  issue_ok;
  logic                  final_issue;
  logic                  pop;
  logic                  drain_exit;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CNT_W:0]        occupancy;
  struct_fetch_word      push_word;
  struct_fetch_word      head_word;

  // A word already in the FIFO or still inside the cache both claim a slot;
  // a pop this cycle frees one, which is what keeps the stream back-to-back.
  assign pop         = !fifo_empty && bus.out_ready;
  assign occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign issue_ok    = pop || (!fifo_full && (occupancy < SKID_LIMIT));
  assign final_issue = (remaining == (ADDR_WIDTH + 1)'(1));
  assign drain_exit  = !inflight && (fifo_empty || (pop && head_word.last));

  assign push_word     = {ccr_out.q, inflight_last};
  assign ccr_in.raddr  = issue_addr;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head_word.data;
  assign bus.out_last  = !fifo_empty && head_word.last;

  cascade_stage_fetcher_skid_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (SKID_DEPTH)
  ) u_skid_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (push_word),
    .pop       (pop),
    .head_data (head_word),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // State register; reset aborts any command in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          next_state = (bus.cmd_count == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (issue && final_issue) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_exit) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-state outputs and the read issue strobe.
  always_comb begin
    bus.cmd_ready = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    issue         = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        busy          = 1'b0;
      end
      FETCH:   issue = issue_ok;
      DRAIN:   issue = 1'b0;
      DONE:    done  = 1'b1;
      default: busy  = 1'b1;
    endcase
  end

  // Issue pointer, words left to issue, and the in-flight marker that tells
  // the FIFO the cache output is meaningful this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_addr    <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && final_issue;
      if (state == IDLE && bus.cmd_valid) begin
        issue_addr <= bus.cmd_addr;
        remaining  <= bus.cmd_count;
      end else if (issue) begin
        issue_addr <= issue_addr + ADDR_WIDTH'(1);
        remaining  <= remaining - (ADDR_WIDTH + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_cascade_stage_fetcher.sv
// Scoreboard bench for the cascade stage fetcher with a behavioural cache.
module tb_cascade_stage_fetcher;
  import cascade_stage_fetcher_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic done;
  struct_cascadeCache_Read_In  ccr_in;
  struct_cascadeCache_Read_Out ccr_out;

  cascade_stage_fetcher_if bus ();

  cascade_stage_fetcher dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .ccr_in  (ccr_in),
    .ccr_out (ccr_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  int hs_cycle = 0;
  int done_cycle = 0;
  int done_pulses = 0;
  int accepts = 0;
  int first_accept = 0;
  int last_accept = 0;
  int ready_mode = 0;
  int ready_phase = 0;
  logic stall_prev = 1'b0;
  logic [WORD_SIZE-1:0] stall_data;
  logic [ADDR_WIDTH-1:0] raddr_q;
  struct_fetch_word exp_q[$];
  struct_fetch_word exp_w;

  // Cache preloaded with word = address; address registered, data unregistered.
  function automatic logic [WORD_SIZE-1:0] cache_word(input logic [ADDR_WIDTH-1:0] a);
    return {{(WORD_SIZE - ADDR_WIDTH){1'b0}}, a};
  endfunction

  always @(posedge clk) raddr_q <= ccr_in.raddr;
  assign ccr_out.q = cache_word(raddr_q);

  always @(posedge clk) cycle_cnt++;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cycle_cnt);
    end
  endtask

  // Consumer ready patterns: 0 = always ready, 1 = 1,0,0,1,0,1 repeating, else stalled.
  function automatic logic ready_value(input int mode, input int phase);
    logic [5:0] pattern;
    pattern = 6'b101001;
    case (mode)
      0:       return 1'b1;
      1:       return pattern[phase % 6];
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    ready_phase++;
    bus.out_ready = ready_value(ready_mode, ready_phase);
  endtask

  // Output monitor: pops the scoreboard on every accepted word and checks that
  // a stalled word stays put.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_output("hold_valid", bus.out_valid, 1'b1);
        check_output("hold_data", bus.out_data, stall_data);
      end
      if (bus.cmd_valid && bus.cmd_ready) hs_cycle = cycle_cnt;
      if (done) begin
        done_pulses++;
        done_cycle = cycle_cnt;
      end
      if (bus.out_valid && bus.out_ready) begin
        check_output("word_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check_output("data", bus.out_data, exp_w.data);
          check_output("last", bus.out_last, exp_w.last);
        end
        if (accepts == 0) first_accept = cycle_cnt;
        last_accept = cycle_cnt;
        accepts++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
    end
  end

  // Runs one stage command to completion; with junk set, cmd_valid stays high
  // with a different command while busy.
  task automatic apply_stimulus(input logic [ADDR_WIDTH-1:0] addr, input int count,
                                input int mode, input bit junk);
    int guard;
    int start_pulses;
    logic [ADDR_WIDTH-1:0] a;
    ready_mode = mode;
    ready_phase = 0;
    bus.out_ready = ready_value(mode, 0);
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin
      step();
      guard++;
    end
    check_output("cmd_ready_idle", bus.cmd_ready, 1'b1);
    a = addr;
    for (int i = 0; i < count; i++) begin
      exp_q.push_back('{data: cache_word(a), last: (i == count - 1)});
      a = a + ADDR_WIDTH'(1);
    end
    accepts = 0;
    start_pulses = done_pulses;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_count = (ADDR_WIDTH + 1)'(count);
    step();
    if (junk) begin
      bus.cmd_addr  = addr ^ ADDR_WIDTH'('h155);
      bus.cmd_count = (ADDR_WIDTH + 1)'(7);
    end else begin
      bus.cmd_valid = 1'b0;
    end
    guard = 0;
    while (!done && guard < 3000) begin
      step();
      guard++;
    end
    bus.cmd_valid = 1'b0;
    check_output("done_seen", done, 1'b1);
    step();
    check_output("cmd_ready_after", bus.cmd_ready, 1'b1);
    check_output("busy_after", busy, 1'b0);
    check_output("done_width", done, 1'b0);
    step();
    check_output("done_pulses", done_pulses - start_pulses, 1);
    check_output("words_left", exp_q.size(), 0);
    check_output("accept_count", accepts, count);
    if (count == 0) begin
      check_output("done_after_hs", done_cycle, hs_cycle + 1);
    end else begin
      check_output("done_after_last", done_cycle, last_accept + 1);
    end
    if (mode == 0 && count > 0) begin
      check_output("first_latency", first_accept, hs_cycle + 3);
      check_output("back_to_back", last_accept - first_accept, count - 1);
    end
  endtask

  // Aborts a command with one word in flight and one in the FIFO.
  task automatic apply_reset_midway();
    ready_mode = 2;
    bus.out_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = ADDR_WIDTH'('h100);
    bus.cmd_count = (ADDR_WIDTH + 1)'(8);
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    check_output("pre_reset_valid", bus.out_valid, 1'b1);
    check_output("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_output("abort_valid", bus.out_valid, 1'b0);
    check_output("abort_busy", busy, 1'b0);
    check_output("abort_ready", bus.cmd_ready, 1'b1);
    check_output("abort_raddr", ccr_in.raddr, 0);
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_count = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_cmd_ready", bus.cmd_ready, 1'b1);
    check_output("reset_out_valid", bus.out_valid, 1'b0);
    check_output("reset_out_last", bus.out_last, 1'b0);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_done", done, 1'b0);
    check_output("reset_raddr", ccr_in.raddr, 0);
    reset = 1'b0;
    step();

    apply_stimulus(ADDR_WIDTH'('h010), 4, 0, 1'b0);
    apply_stimulus(ADDR_WIDTH'('h010), 4, 1, 1'b0);
    apply_stimulus(ADDR_WIDTH'((1 << ADDR_WIDTH) - 2), 4, 0, 1'b0);
    apply_stimulus(ADDR_WIDTH'('h000), 0, 0, 1'b0);
    apply_reset_midway();
    apply_stimulus(ADDR_WIDTH'('h020), 3, 0, 1'b0);
    apply_stimulus(ADDR_WIDTH'('h040), 5, 0, 1'b1);
    apply_stimulus(ADDR_WIDTH'('h080), 6, 1, 1'b1);
    apply_stimulus(ADDR_WIDTH'('h000), 1 << ADDR_WIDTH, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
